vector_viewport_mapper: RTL and testbench

Parametrised, pipelined successor to the vector component extractor in the vertex path.
- Takes one packed 4-component vector from a vector register.
- Maps the X and Y fixed-point components from world space to unsigned screen pixel coordinates: origin shift, constant scale, rounding and clamping.
- Passes components 0/1 through, delay-matched.
- Sits between vector register read and the rasteriser, with a valid/ready handshake on both sides.

---
 rtl/vvm_pkg.sv | 28 ++
 rtl/vector_viewport_mapper_if.sv | 32 +++
 rtl/vvm_axis_map.sv | 85 ++++++++
 rtl/vector_viewport_mapper.sv | 78 +++++++
 tb/tb_vector_viewport_mapper.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/vvm_pkg.sv
// vvm_pkg: shared definitions for vector_viewport_mapper.
//   - clog2 helper used to size the scale products
//   - default geometry and the derived datapath widths for that geometry
//   - bit positions of the X/Y clip flags inside out_clipped
package vvm_pkg;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  localparam int COMP_W   = 16;
  localparam int FRAC_W   = 7;
  localparam int SCALE_X  = 64;
  localparam int SCALE_Y  = 40;

  localparam int OFF_W    = COMP_W + 2;
  localparam int PROD_W   = OFF_W + int'(clog2((SCALE_X > SCALE_Y) ? SCALE_X : SCALE_Y)) + 1;
  localparam int ONE_HALF = 1 << (FRAC_W - 1);

  localparam int CLIP_X   = 0;
  localparam int CLIP_Y   = 1;

endpackage

// File: rtl/vector_viewport_mapper_if.sv
// vector_viewport_mapper_if: input and output valid/ready channels of the
// viewport mapper.
//   in_valid/in_ready/in_vector_val    : vector from the register read stage
//   out_valid/out_ready/out_component* : mapped vector toward the rasteriser
//   out_clipped                        : {y_clipped, x_clipped}
// slave modport = mapper side, master modport = producer/consumer side.
interface vector_viewport_mapper_if #(
  parameter int COMP_W = 16
);
  logic                  in_valid;
  logic                  in_ready;
  logic [4*COMP_W-1:0]   in_vector_val;
  logic                  out_valid;
  logic                  out_ready;
  logic [COMP_W-1:0]     out_component0;
  logic [COMP_W-1:0]     out_component1;
  logic [COMP_W-1:0]     out_component2;
  logic [COMP_W-1:0]     out_component3;
  logic [1:0]            out_clipped;

  modport slave (
    input  in_valid, in_vector_val, out_ready,
    output in_ready, out_valid, out_component0, out_component1,
           out_component2, out_component3, out_clipped
  );

  modport master (
    output in_valid, in_vector_val, out_ready,
    input  in_ready, out_valid, out_component0, out_component1,
           out_component2, out_component3, out_clipped
  );
endinterface

// File: rtl/vvm_axis_map.sv
// vvm_axis_map: one axis of the viewport mapping, three register stages.
//   clk_i, rst_ni : clock, synchronous active-low reset
//   en_i          : global pipeline enable (all stages advance together)
//   comp_i        : signed fixed-point world coordinate
//   coord_o       : unsigned screen coordinate, clamped to [0, SCREEN_MAX]
//   clip_o        : set when clamping was applied
// INVERT = 0 adds the origin offset (X), INVERT = 1 subtracts the input (Y).
// Build option VECTOR_VIEWPORT_MAPPER_ROUND_EN: round half up before the
// shift; otherwise the shift truncates toward minus infinity.
module vvm_axis_map #(
  parameter int COMP_W     = 16,
  parameter int FRAC_W     = 7,
  parameter int HALF_RANGE = 5,
  parameter int SCALE      = 64,
  parameter int SCREEN_MAX = 639,
  parameter int INVERT     = 0
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     en_i,
  input  logic signed [COMP_W-1:0] comp_i,
  output logic        [COMP_W-1:0] coord_o,
  output logic                     clip_o
);
  localparam int OFF_W  = COMP_W + 2;
  localparam int PROD_W = OFF_W + int'(vvm_pkg::clog2(SCALE)) + 1;
  // One extra bit so the rounding add can never wrap.
  localparam int Q_W    = PROD_W + 1;

  localparam logic signed [OFF_W-1:0]  ORIGIN  = OFF_W'(HALF_RANGE << FRAC_W);
  localparam logic signed [PROD_W-1:0] SCALE_C = PROD_W'(SCALE);
  localparam logic signed [Q_W-1:0]    MAX_C   = Q_W'(SCREEN_MAX);

  logic signed [OFF_W-1:0]  off_d, off_q;
  logic signed [PROD_W-1:0] prod_d, prod_q;
  logic signed [Q_W-1:0]    sum, q;
  logic        [COMP_W-1:0] coord_d, coord_q;
  logic                     clip_d, clip_q;

  always_comb begin
    off_d = '0;
    if (INVERT != 0) off_d = ORIGIN - OFF_W'(comp_i);
    else             off_d = OFF_W'(comp_i) + ORIGIN;
  end

  always_comb begin
    prod_d = PROD_W'(off_q) * SCALE_C;
  end

  always_comb begin
`ifdef VECTOR_VIEWPORT_MAPPER_ROUND_EN
    sum = Q_W'(prod_q) + Q_W'(1 << (FRAC_W - 1));
`else
    sum = Q_W'(prod_q);
`endif
    q       = sum >>> FRAC_W;
    coord_d = '0;
    clip_d  = 1'b0;
    if (q < 0) begin
      clip_d = 1'b1;
    end else if (q > MAX_C) begin
      coord_d = COMP_W'(MAX_C);
      clip_d  = 1'b1;
    end else begin
      coord_d = COMP_W'(q);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      off_q   <= '0;
      prod_q  <= '0;
      coord_q <= '0;
      clip_q  <= 1'b0;
    end else if (en_i) begin
      off_q   <= off_d;
      prod_q  <= prod_d;
      coord_q <= coord_d;
      clip_q  <= clip_d;
    end
  end

  assign coord_o = coord_q;
  assign clip_o  = clip_q;
endmodule

// File: rtl/vector_viewport_mapper.sv
// vector_viewport_mapper: maps the X/Y components of a packed 4-component
// fixed-point vector to screen column/row, passing comp0/comp1 through.
//   clock, reset_n : clock, synchronous active-low reset
//   bus (slave)    : in_* channel (comp3 = X in MSBs, comp2 = Y, comp0 LSBs)
//                    and out_* channel (comp3 = column, comp2 = row,
//                    out_clipped = {y_clipped, x_clipped})
// Three stages, one global enable; a stalled output freezes every stage.
// Build option VECTOR_VIEWPORT_MAPPER_ROUND_EN selects round-half-up.
module vector_viewport_mapper
  import vvm_pkg::*;
#(
  parameter int COMP_W     = 16,
  parameter int FRAC_W     = 7,
  parameter int HALF_RANGE = 5,
  parameter int SCALE_X    = 64,
  parameter int SCALE_Y    = 40,
  parameter int SCREEN_W   = 640,
  parameter int SCREEN_H   = 400
) (
  input logic                    clock,
  input logic                    reset_n,
  vector_viewport_mapper_if.slave bus
);
  logic                   en;
  logic [2:0]             valid_q;
  logic [2:0][COMP_W-1:0] c0_q, c1_q;
  logic [COMP_W-1:0]      col, row;
  logic                   x_clip, y_clip;
  logic [1:0]             clipped;

  assign en           = !valid_q[2] || bus.out_ready;
  assign bus.in_ready = en && reset_n;

  vvm_axis_map #(
    .COMP_W(COMP_W), .FRAC_W(FRAC_W), .HALF_RANGE(HALF_RANGE),
    .SCALE(SCALE_X), .SCREEN_MAX(SCREEN_W - 1), .INVERT(0)
  ) u_x (
    .clk_i(clock), .rst_ni(reset_n), .en_i(en),
    .comp_i(bus.in_vector_val[4*COMP_W-1 -: COMP_W]),
    .coord_o(col), .clip_o(x_clip)
  );

  vvm_axis_map #(
    .COMP_W(COMP_W), .FRAC_W(FRAC_W), .HALF_RANGE(HALF_RANGE),
    .SCALE(SCALE_Y), .SCREEN_MAX(SCREEN_H - 1), .INVERT(1)
  ) u_y (
    .clk_i(clock), .rst_ni(reset_n), .en_i(en),
    .comp_i(bus.in_vector_val[3*COMP_W-1 -: COMP_W]),
    .coord_o(row), .clip_o(y_clip)
  );

  // Valid and passthrough shift in lockstep with the axis datapaths; with en
  // high, stage 1 loads in_valid, which equals the input transfer condition.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      valid_q <= '0;
      c0_q    <= '0;
      c1_q    <= '0;
    end else if (en) begin
      valid_q <= {valid_q[1:0], bus.in_valid};
      c0_q    <= {c0_q[1:0], bus.in_vector_val[COMP_W-1:0]};
      c1_q    <= {c1_q[1:0], bus.in_vector_val[2*COMP_W-1 -: COMP_W]};
    end
  end

  always_comb begin
    clipped         = '0;
    clipped[CLIP_X] = x_clip;
    clipped[CLIP_Y] = y_clip;
  end

  assign bus.out_valid      = valid_q[2];
  assign bus.out_component0 = c0_q[2];
  assign bus.out_component1 = c1_q[2];
  assign bus.out_component2 = row;
  assign bus.out_component3 = col;
  assign bus.out_clipped    = clipped;
endmodule

// File: tb/tb_vector_viewport_mapper.sv
module tb_vector_viewport_mapper;
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clock = ~clock;

  vector_viewport_mapper_if #(.COMP_W(16)) bus ();

  vector_viewport_mapper #(
    .COMP_W(16), .FRAC_W(7), .HALF_RANGE(5), .SCALE_X(64), .SCALE_Y(40),
    .SCREEN_W(640), .SCREEN_H(400)
  ) dut (
    .clock(clock), .reset_n(reset_n), .bus(bus)
  );

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Sends one vector with out_ready held high and returns what emerges.
  // lat counts clock edges from the accepting edge to the first out_valid.
  task automatic run_single(input logic [15:0] x, input logic [15:0] y,
                            input logic [15:0] c1, input logic [15:0] c0,
                            output int lat, output logic [15:0] col,
                            output logic [15:0] row, output logic [31:0] pass,
                            output logic [1:0] clip);
    bus.out_ready     = 1'b1;
    bus.in_vector_val = {x, y, c1, c0};
    bus.in_valid      = 1'b1;
    step();
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 12) begin
      step();
      lat++;
    end
    col  = bus.out_component3;
    row  = bus.out_component2;
    pass = {bus.out_component1, bus.out_component0};
    clip = bus.out_clipped;
  endtask

  task automatic test_reset();
    reset_n           = 1'b0;
    bus.in_valid      = 1'b1;
    bus.out_ready     = 1'b1;
    bus.in_vector_val = 64'h0280_FD80_BEEF_1234;
    step();
    step();
    checks++;
    if (bus.in_ready !== 1'b0) begin
      errors++; $display("FAIL reset_in_ready: got %b expected 0", bus.in_ready);
    end
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid);
    end
    checks++;
    if ({bus.out_component3, bus.out_component2, bus.out_component1,
         bus.out_component0, bus.out_clipped} !== 66'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %h %h %h %h %b expected all zero",
               bus.out_component3, bus.out_component2, bus.out_component1,
               bus.out_component0, bus.out_clipped);
    end
    bus.in_valid = 1'b0;
    reset_n      = 1'b1;
    step();
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL post_reset_in_ready: got %b expected 1", bus.in_ready);
    end
  endtask

  task automatic test_center();
    int lat; logic [15:0] col, row; logic [31:0] pass; logic [1:0] clip;
    run_single(16'h0000, 16'h0000, 16'hBEEF, 16'h1234, lat, col, row, pass, clip);
    checks++;
    if (lat !== 3) begin errors++; $display("FAIL center_latency: got %0d expected 3", lat); end
    checks++;
    if (col !== 16'd320) begin errors++; $display("FAIL center_col: got %0d expected 320", col); end
    checks++;
    if (row !== 16'd200) begin errors++; $display("FAIL center_row: got %0d expected 200", row); end
    checks++;
    if (pass !== 32'hBEEF_1234) begin
      errors++; $display("FAIL center_pass: got %h expected beef1234", pass);
    end
    checks++;
    if (clip !== 2'b00) begin errors++; $display("FAIL center_clip: got %b expected 00", clip); end
  endtask

  task automatic test_rounding();
    int lat; logic [15:0] col, row, ecol, erow; logic [31:0] pass; logic [1:0] clip;
`ifdef VECTOR_VIEWPORT_MAPPER_ROUND_EN
    ecol = 16'd321; erow = 16'd200;
`else
    ecol = 16'd320; erow = 16'd199;
`endif
    run_single(16'h0001, 16'h0001, 16'h5555, 16'hAAAA, lat, col, row, pass, clip);
    checks++;
    if (col !== ecol) begin errors++; $display("FAIL round_col: got %0d expected %0d", col, ecol); end
    checks++;
    if (row !== erow) begin errors++; $display("FAIL round_row: got %0d expected %0d", row, erow); end
    checks++;
    if (clip !== 2'b00) begin errors++; $display("FAIL round_clip: got %b expected 00", clip); end
  endtask

  task automatic test_x_range();
    int lat; logic [15:0] col, row; logic [31:0] pass; logic [1:0] clip;
    run_single(16'h0280, 16'hFD80, 16'h0001, 16'h0002, lat, col, row, pass, clip);
    checks++;
    if (col !== 16'd639) begin errors++; $display("FAIL max_col: got %0d expected 639", col); end
    checks++;
    if (row !== 16'd399) begin errors++; $display("FAIL max_row: got %0d expected 399", row); end
    checks++;
    if (clip !== 2'b11) begin errors++; $display("FAIL max_clip: got %b expected 11", clip); end
    run_single(16'hFD80, 16'h0280, 16'h0003, 16'h0004, lat, col, row, pass, clip);
    checks++;
    if (col !== 16'd0) begin errors++; $display("FAIL min_col: got %0d expected 0", col); end
    checks++;
    if (row !== 16'd0) begin errors++; $display("FAIL min_row: got %0d expected 0", row); end
    checks++;
    if (clip !== 2'b00) begin errors++; $display("FAIL min_clip: got %b expected 00", clip); end
    checks++;
    if (pass !== 32'h0003_0004) begin
      errors++; $display("FAIL min_pass: got %h expected 00030004", pass);
    end
  endtask

  task automatic test_extremes();
    int lat; logic [15:0] col, row; logic [31:0] pass; logic [1:0] clip;
    run_single(16'h8000, 16'h7FFF, 16'hFFFF, 16'h0000, lat, col, row, pass, clip);
    checks++;
    if (col !== 16'd0) begin errors++; $display("FAIL extreme_col: got %0d expected 0", col); end
    checks++;
    if (row !== 16'd0) begin errors++; $display("FAIL extreme_row: got %0d expected 0", row); end
    checks++;
    if (clip !== 2'b11) begin errors++; $display("FAIL extreme_clip: got %b expected 11", clip); end
    run_single(16'h7FFF, 16'h8000, 16'h0000, 16'hFFFF, lat, col, row, pass, clip);
    checks++;
    if ({col, row, clip} !== {16'd639, 16'd399, 2'b11}) begin
      errors++;
      $display("FAIL extreme_high: got col %0d row %0d clip %b expected 639 399 11", col, row, clip);
    end
  endtask

  task automatic test_reset_flush();
    int seen = 0;
    bus.out_ready     = 1'b1;
    bus.in_vector_val = 64'h0000_0000_1111_2222;
    bus.in_valid      = 1'b1;
    step();
    bus.in_valid = 1'b0;
    reset_n      = 1'b0;
    step();
    reset_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (bus.out_valid) seen++;
      step();
    end
    checks++;
    if (seen !== 0) begin
      errors++; $display("FAIL reset_flush: got %0d outputs expected 0", seen);
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] exp_col [8] = '{16'd64, 16'd128, 16'd192, 16'd256,
                                 16'd320, 16'd384, 16'd448, 16'd512};
    logic [15:0] exp_row [8] = '{16'd320, 16'd280, 16'd240, 16'd200,
                                 16'd160, 16'd120, 16'd80, 16'd40};
    logic [3:0]  pat = 4'b1001;
    logic        held = 1'b0;
    logic [66:0] held_val = '0;
    logic [66:0] cur;
    int in_idx = 0, out_idx = 0, cyc = 0, extra = 0;
    while (out_idx < 8 && cyc < 200) begin
      bus.out_ready = pat[cyc % 4];
      if (in_idx < 8) begin
        bus.in_valid      = 1'b1;
        bus.in_vector_val = {16'((in_idx - 4) * 128), 16'((in_idx - 3) * 128),
                             16'(16'hA000 | in_idx), 16'(in_idx)};
      end else begin
        bus.in_valid = 1'b0;
      end
      #1;
      cur = {bus.out_valid, bus.out_component3, bus.out_component2,
             bus.out_component1, bus.out_component0, bus.out_clipped};
      if (held) begin
        checks++;
        if (cur !== held_val) begin
          errors++; $display("FAIL bp_hold: got %h expected %h", cur, held_val);
        end
      end
      if (bus.out_valid && bus.out_ready) begin
        checks++;
        if (cur !== {1'b1, exp_col[out_idx], exp_row[out_idx],
                     16'(16'hA000 | out_idx), 16'(out_idx), 2'b00}) begin
          errors++;
          $display("FAIL bp_data[%0d]: got %h expected col %0d row %0d comp1 %h comp0 %h clip 00",
                   out_idx, cur, exp_col[out_idx], exp_row[out_idx],
                   16'(16'hA000 | out_idx), out_idx);
        end
        out_idx++;
      end
      held     = bus.out_valid && !bus.out_ready;
      held_val = cur;
      if (bus.in_valid && bus.in_ready) in_idx++;
      step();
      cyc++;
    end
    checks++;
    if (out_idx !== 8) begin
      errors++; $display("FAIL bp_count: got %0d outputs expected 8", out_idx);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (bus.out_valid) extra++;
      step();
    end
    checks++;
    if (extra !== 0) begin
      errors++; $display("FAIL bp_extra: got %0d extra outputs expected 0", extra);
    end
  endtask

  initial begin
    bus.in_valid      = 1'b0;
    bus.out_ready     = 1'b0;
    bus.in_vector_val = '0;
    test_reset();
    test_center();
    test_rounding();
    test_x_range();
    test_extremes();
    test_reset_flush();
    test_backpressure();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
